processing_unit: RTL

Datapath of the 8-bit CPU: the stage directly downstream of the control unit, consuming its load/increment strobes and bus-mux selects every cycle. Holds general registers R0–R3, PC, IR, operand register Y, zero flag Z and the memory address register. Routes data over two internal buses through a 4-operation ALU. Returns the current instruction and the zero flag to the control unit.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/alu.sv | 22 ++
 rtl/processing_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: word sizes, opcodes, register indices
// and bus select codes used by both the control unit and the datapath.
package cpu_pkg;

    localparam int word_size     = 8;
    localparam int opcode_size   = 4;
    localparam int sel_bus1_size = 3;
    localparam int sel_bus2_size = 2;

    typedef enum logic [opcode_size-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        AND = 4'd3,
        NOT = 4'd4,
        RD  = 4'd5,
        WR  = 4'd6,
        BR  = 4'd7,
        BRZ = 4'd8
    } opcode_t;

    localparam logic [1:0] r0 = 2'd0;
    localparam logic [1:0] r1 = 2'd1;
    localparam logic [1:0] r2 = 2'd2;
    localparam logic [1:0] r3 = 2'd3;

    // Codes 5-7 on bus_1 and 3 on bus_2 are unassigned and drive zero.
    typedef enum logic [sel_bus1_size-1:0] {
        SEL_R0 = 3'd0,
        SEL_R1 = 3'd1,
        SEL_R2 = 3'd2,
        SEL_R3 = 3'd3,
        SEL_PC = 3'd4
    } bus1_sel_t;

    typedef enum logic [sel_bus2_size-1:0] {
        SEL_ALU  = 2'd0,
        SEL_BUS1 = 2'd1,
        SEL_MEM  = 2'd2
    } bus2_sel_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-operation ALU: a comes from Y, b from bus_1.
module alu
    import cpu_pkg::*;
(
    input  logic [word_size-1:0]   a,
    input  logic [word_size-1:0]   b,
    input  logic [opcode_size-1:0] opcode,
    output logic [word_size-1:0]   alu_out
);

    always_comb begin
        alu_out = '0;
        case (opcode)
            ADD:     alu_out = a + b;
            SUB:     alu_out = b - a;   // operand order: bus_1 minus Y
            AND:     alu_out = a & b;
            NOT:     alu_out = ~b;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/processing_unit.sv
// CPU datapath: R0-R3, PC, IR, Y, Z and address register around two
// combinational buses and the ALU, driven by control-unit strobes.
module processing_unit
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_r0,
    input  logic                     load_r1,
    input  logic                     load_r2,
    input  logic                     load_r3,
    input  logic                     load_pc,
    input  logic                     inc_pc,
    input  logic                     load_ir,
    input  logic                     load_y,
    input  logic                     load_z,
    input  logic                     load_addr_reg,
    input  logic [sel_bus1_size-1:0] sel_bus_1_mux,
    input  logic [sel_bus2_size-1:0] sel_bus_2_mux,
    input  logic [word_size-1:0]     mem_word,
    output logic [word_size-1:0]     instruction,
    output logic                     zero,
    output logic [word_size-1:0]     address,
    output logic [word_size-1:0]     bus_1
);

    logic [word_size-1:0] r0_q, r1_q, r2_q, r3_q;
    logic [word_size-1:0] pc_q, ir_q, y_q, addr_q;
    logic                 z_q;
    logic [word_size-1:0] bus_2;
    logic [word_size-1:0] alu_out;

    always_comb begin
        bus_1 = '0;
        case (sel_bus_1_mux)
            SEL_R0:  bus_1 = r0_q;
            SEL_R1:  bus_1 = r1_q;
            SEL_R2:  bus_1 = r2_q;
            SEL_R3:  bus_1 = r3_q;
            SEL_PC:  bus_1 = pc_q;
            default: bus_1 = '0;
        endcase
    end

    always_comb begin
        bus_2 = '0;
        case (sel_bus_2_mux)
            SEL_ALU:  bus_2 = alu_out;
            SEL_BUS1: bus_2 = bus_1;
            SEL_MEM:  bus_2 = mem_word;
            default:  bus_2 = '0;
        endcase
    end

    // Opcode comes straight from IR, so an IR load changes the ALU op at once.
    alu u_alu (
        .a       (y_q),
        .b       (bus_1),
        .opcode  (ir_q[word_size-1 -: opcode_size]),
        .alu_out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q   <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            y_q    <= '0;
            addr_q <= '0;
            z_q    <= 1'b0;
        end else begin
            if (load_r0)       r0_q   <= bus_2;
            if (load_r1)       r1_q   <= bus_2;
            if (load_r2)       r2_q   <= bus_2;
            if (load_r3)       r3_q   <= bus_2;
            if (load_ir)       ir_q   <= bus_2;
            if (load_y)        y_q    <= bus_2;
            if (load_addr_reg) addr_q <= bus_2;
            if (load_z)        z_q    <= (alu_out == '0);
            // A jump target wins over sequential increment.
            if (load_pc)       pc_q   <= bus_2;
            else if (inc_pc)   pc_q   <= pc_q + 1'b1;
        end
    end

    assign instruction = ir_q;
    assign zero        = z_q;
    assign address     = addr_q;

endmodule
